// File: rtl/vec_stream_tx_pkg.sv
// Shared types for the double-buffered vector transmitter.
package vec_stream_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/vec_stream_tx_if.sv
// Host write port plus outgoing valid/ready word stream of vec_stream_tx.
interface vec_stream_tx_if #(
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int logN = $clog2(N)
);
    logic            wr_en;
    logic [logN-1:0] wr_addr;
    logic [T-1:0]    wr_data;
    logic            commit;
    logic            load_ready;
    logic            m_valid;
    logic            m_ready;
    logic [T-1:0]    data_out;
    logic            frame_done;

    modport master (
        input  wr_en, wr_addr, wr_data, commit, m_ready,
        output load_ready, m_valid, data_out, frame_done
    );

    modport slave (
        output wr_en, wr_addr, wr_data, commit, m_ready,
        input  load_ready, m_valid, data_out, frame_done
    );
endinterface

// File: rtl/vec_bank_ram.sv
// Two-bank vector store: one synchronous write port, one synchronous read port.
module vec_bank_ram #(
    parameter int WIDTH   = 16,
    parameter int SIZE    = 16,
    parameter int LOGSIZE = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [LOGSIZE-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [LOGSIZE-1:0] raddr,
    output logic [WIDTH-1:0]   q
);
    logic [WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        q <= mem[raddr];
    end
endmodule

// File: rtl/vec_stream_tx.sv
// Double-buffered vector transmitter: host fills one bank while the other streams out.
//   state | meaning
//   IDLE  | waiting for the read bank to be committed; read of word 0 is issued
//   FETCH | word 0 arriving from the RAM; m_valid rises next cycle
//   SEND  | streaming words of the read bank over valid/ready
module vec_stream_tx
    import vec_stream_tx_pkg::*;
#(
    parameter int N    = 8,
    parameter int T    = 16,
    parameter int logN = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    vec_stream_tx_if.master bus
);
    tx_state_t       state_q, state_d;
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [logN-1:0] cnt_q, cnt_d;
    logic            m_valid_q, m_valid_d;

    logic            load_ready;
    logic            commit_ok;
    logic            we;
    logic            handshake;
    logic            last_word;
    logic            release_bank;
    logic [logN-1:0] rd_idx;
    logic [logN:0]   raddr;
    logic [logN:0]   waddr;
    logic [T-1:0]    ram_q;

    assign load_ready   = !full_q[wr_bank_q];
    assign commit_ok    = bus.commit && load_ready;
    assign we           = bus.wr_en && load_ready;
    assign handshake    = m_valid_q && bus.m_ready;
    assign last_word    = (cnt_q == logN'(N - 1));
    assign release_bank = handshake && last_word;

    // Look one word ahead on a handshake so the next word is ready without a bubble.
    assign rd_idx = handshake ? cnt_q + logN'(1) : cnt_q;
    assign raddr  = {rd_bank_q, rd_idx};
    assign waddr  = {wr_bank_q, bus.wr_addr};

    vec_bank_ram #(
        .WIDTH   (T),
        .SIZE    (2 * N),
        .LOGSIZE (logN + 1)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.wr_data),
        .raddr (raddr),
        .q     (ram_q)
    );

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;

        if (commit_ok) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d   = SEND;
                m_valid_d = 1'b1;
            end
            SEND: begin
                if (handshake) begin
                    if (last_word) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = !rd_bank_q;
                        cnt_d             = '0;
                        m_valid_d         = 1'b0;
                        // A commit landing this same cycle still chains straight into FETCH.
                        state_d           = full_d[!rd_bank_q] ? FETCH : IDLE;
                    end else begin
                        cnt_d = cnt_q + logN'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.m_valid    = m_valid_q;
    assign bus.data_out   = m_valid_q ? ram_q : '0;
    assign bus.frame_done = release_bank;
endmodule
